// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters,
// MEM-stage resolution/mispredict detection and lookup/mispredict performance counters.
module branch_target_predictor #(
    parameter int ENTRIES  = 16,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        upd_is_jump,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] perf_lookups,
    output logic [31:0] perf_mispredicts
);

    localparam int IDX = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1) << (CTR_BITS - 1);

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic                jump_q   [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic [IDX-1:0]      lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic                lk_hit;
    logic [IDX-1:0]      up_idx;
    logic [TAG_BITS-1:0] up_tag;
    logic                up_hit;
    logic                upd_en;

    assign lk_idx = if_pc[IDX+1:2];
    assign lk_tag = if_pc[IDX+TAG_BITS+1:IDX+2];
    assign up_idx = upd_pc[IDX+1:2];
    assign up_tag = upd_pc[IDX+TAG_BITS+1:IDX+2];

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // A stalled update stays on the inputs, so gating on stall applies it exactly once.
    assign upd_en = upd_valid && !stall && !reset;

    assign pred_taken  = !reset && lk_hit && (jump_q[lk_idx] || ctr_q[lk_idx][CTR_BITS-1]);
    assign pred_target = pred_taken ? target_q[lk_idx] : if_pc + 32'd4;

    assign mispredict  = upd_valid &&
                         ((upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                jump_q[i]  <= 1'b0;
                ctr_q[i]   <= '0;
            end
        end else if (upd_en) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (ctr_q[up_idx] != CTR_MAX)
                        ctr_q[up_idx] <= ctr_q[up_idx] + CTR_BITS'(1);
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_q[up_idx] <= ctr_q[up_idx] - CTR_BITS'(1);
                end
                jump_q[up_idx] <= upd_is_jump;
            end else if (upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                jump_q[up_idx]  <= upd_is_jump;
                ctr_q[up_idx]   <= CTR_INIT;
            end
        end
    end

    // Tags and targets carry no reset; valid alone decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (upd_en && upd_taken) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_lookups     <= '0;
            perf_mispredicts <= '0;
        end else if (!stall) begin
            perf_lookups <= perf_lookups + 32'd1;
            if (mispredict)
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: directed scenarios plus a randomized
// run compared against an array-based reference model of the prediction table.
module tb_branch_target_predictor;

    localparam int ENTRIES  = 16;
    localparam int TAG_BITS = 8;
    localparam int CTR_BITS = 2;
    localparam int IDX      = 4;
    localparam int CTR_MAX  = (1 << CTR_BITS) - 1;
    localparam int CTR_HALF = 1 << (CTR_BITS - 1);

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_is_jump;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] perf_lookups;
    logic [31:0] perf_mispredicts;

    int n_cmp = 0;
    int n_err = 0;

    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    bit          m_jump   [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_lookups;
    logic [31:0] m_mis;

    branch_target_predictor #(
        .ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .CTR_BITS(CTR_BITS)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_is_jump(upd_is_jump),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .perf_lookups(perf_lookups), .perf_mispredicts(perf_mispredicts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pc_index(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned pc_tag(input logic [31:0] pc);
        return int'((pc >> (IDX + 2)) % (1 << TAG_BITS));
    endfunction

    function automatic void model_predict(input logic [31:0] pc, input logic rst,
                                          output logic t, output logic [31:0] tgt);
        int i;
        bit hit;
        i   = pc_index(pc);
        hit = m_valid[i] && (m_tag[i] == pc_tag(pc));
        t   = !rst && hit && (m_jump[i] || (m_ctr[i] >= CTR_HALF));
        tgt = t ? m_target[i] : pc + 32'd4;
    endfunction

    function automatic logic model_mispredict();
        if (!upd_valid) return 1'b0;
        if (upd_taken != upd_pred_taken) return 1'b1;
        return upd_taken && (upd_target != upd_pred_target);
    endfunction

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
        upd_valid       = v;
        upd_pc          = pc;
        upd_taken       = taken;
        upd_target      = tgt;
        upd_is_jump     = 1'b0;
        upd_pred_taken  = ptaken;
        upd_pred_target = ptgt;
    endtask

    // Advance one clock edge and apply the architectural effect of the current inputs.
    task automatic tick();
        logic        mp;
        int          i;
        int unsigned t;
        mp = model_mispredict();
        i  = pc_index(upd_pc);
        t  = pc_tag(upd_pc);
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 1'b0;
                m_jump[k]  = 1'b0;
                m_ctr[k]   = 0;
            end
            m_lookups = 0;
            m_mis     = 0;
        end else if (!stall) begin
            m_lookups = m_lookups + 1;
            if (mp) m_mis = m_mis + 1;
            if (upd_valid) begin
                if (m_valid[i] && m_tag[i] == t) begin
                    if (upd_taken) begin
                        m_ctr[i]    = (m_ctr[i] < CTR_MAX) ? m_ctr[i] + 1 : CTR_MAX;
                        m_target[i] = upd_target;
                    end else begin
                        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                    end
                    m_jump[i] = upd_is_jump;
                end else if (upd_taken) begin
                    m_valid[i]  = 1'b1;
                    m_tag[i]    = t;
                    m_target[i] = upd_target;
                    m_jump[i]   = upd_is_jump;
                    m_ctr[i]    = CTR_HALF;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stall = 1'b0;
        if_pc = 32'h60;
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_err++; $display("[TB] FAIL reset_pred_taken got %0b want 0", pred_taken);
        end
        n_cmp++;
        if (pred_target !== 32'h64) begin
            n_err++; $display("[TB] FAIL reset_pred_target got %h want 00000064", pred_target);
        end
        n_cmp++;
        if (perf_lookups !== 32'h0) begin
            n_err++; $display("[TB] FAIL reset_perf_lookups got %0d want 0", perf_lookups);
        end
        n_cmp++;
        if (perf_mispredicts !== 32'h0) begin
            n_err++; $display("[TB] FAIL reset_perf_mispredicts got %0d want 0", perf_mispredicts);
        end
    endtask

    task automatic test_pc_wrap();
        if_pc = 32'hFFFF_FFFC;
        #1;
        n_cmp++;
        if (pred_target !== 32'h0) begin
            n_err++; $display("[TB] FAIL pc_wrap_target got %h want 00000000", pred_target);
        end
        tick();
    endtask

    task automatic test_allocate();
        if_pc = 32'h60;
        set_upd(1'b1, 32'h60, 1'b1, 32'h100, 1'b0, 32'h64);
        #1;
        n_cmp++;
        if (mispredict !== 1'b1) begin
            n_err++; $display("[TB] FAIL alloc_mispredict got %0b want 1", mispredict);
        end
        n_cmp++;
        if (redirect_pc !== 32'h100) begin
            n_err++; $display("[TB] FAIL alloc_redirect got %h want 00000100", redirect_pc);
        end
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_err++; $display("[TB] FAIL same_cycle_pre_update got %0b want 0", pred_taken);
        end
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_cmp++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin
            n_err++; $display("[TB] FAIL alloc_lookup got %0b/%h want 1/00000100", pred_taken, pred_target);
        end
        n_cmp++;
        if (perf_mispredicts !== m_mis) begin
            n_err++; $display("[TB] FAIL alloc_perf_mis got %0d want %0d", perf_mispredicts, m_mis);
        end
    endtask

    task automatic test_saturation();
        if_pc = 32'h60;
        for (int k = 0; k < 2; k++) begin
            set_upd(1'b1, 32'h60, 1'b1, 32'h100, 1'b1, 32'h100);
            #1;
            n_cmp++;
            if (mispredict !== 1'b0) begin
                n_err++; $display("[TB] FAIL sat_taken_mispredict got %0b want 0", mispredict);
            end
            tick();
        end
        set_upd(1'b1, 32'h60, 1'b0, 32'h100, 1'b1, 32'h100);
        #1;
        n_cmp++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h64) begin
            n_err++; $display("[TB] FAIL sat_nt_redirect got %0b/%h want 1/00000064", mispredict, redirect_pc);
        end
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_cmp++;
        if (pred_taken !== 1'b1) begin
            n_err++; $display("[TB] FAIL hysteresis_ctr2 got %0b want 1", pred_taken);
        end
        set_upd(1'b1, 32'h60, 1'b0, 32'h100, 1'b1, 32'h100);
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h64) begin
            n_err++; $display("[TB] FAIL hysteresis_ctr1 got %0b/%h want 0/00000064", pred_taken, pred_target);
        end
    endtask

    task automatic test_alias();
        set_upd(1'b1, 32'h60, 1'b1, 32'h100, 1'b0, 32'h64);
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        if_pc = 32'hA0;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_err++; $display("[TB] FAIL alias_miss got %0b want 0", pred_taken);
        end
        set_upd(1'b1, 32'hA0, 1'b1, 32'h200, 1'b0, 32'hA4);
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_cmp++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            n_err++; $display("[TB] FAIL alias_replace got %0b/%h want 1/00000200", pred_taken, pred_target);
        end
        if_pc = 32'h60;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h64) begin
            n_err++; $display("[TB] FAIL alias_evicted got %0b/%h want 0/00000064", pred_taken, pred_target);
        end
    endtask

    task automatic test_stall();
        logic [31:0] mis_before;
        logic [31:0] look_before;
        mis_before  = m_mis;
        look_before = m_lookups;
        if_pc = 32'h44;
        set_upd(1'b1, 32'h44, 1'b1, 32'h300, 1'b0, 32'h48);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (perf_mispredicts !== mis_before || perf_lookups !== look_before) begin
                n_err++; $display("[TB] FAIL stall_hold_perf got %0d/%0d want %0d/%0d",
                                  perf_lookups, perf_mispredicts, look_before, mis_before);
            end
        end
        stall = 1'b0;
        tick();
        n_cmp++;
        if (perf_mispredicts !== mis_before + 32'd1) begin
            n_err++; $display("[TB] FAIL stall_release_mis got %0d want %0d", perf_mispredicts, mis_before + 32'd1);
        end
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_cmp++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
            n_err++; $display("[TB] FAIL stall_alloc got %0b/%h want 1/00000300", pred_taken, pred_target);
        end
        set_upd(1'b1, 32'h44, 1'b0, 32'h300, 1'b1, 32'h300);
        tick();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_err++; $display("[TB] FAIL stall_single_apply got %0b want 0", pred_taken);
        end
    endtask

    task automatic test_reset_midop();
        if_pc = 32'hA0;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b1) begin
            n_err++; $display("[TB] FAIL midop_prehit got %0b want 1", pred_taken);
        end
        reset = 1'b1;
        set_upd(1'b1, 32'h80, 1'b1, 32'h400, 1'b0, 32'h84);
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_err++; $display("[TB] FAIL midop_forced_zero got %0b want 0", pred_taken);
        end
        tick();
        reset = 1'b0;
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        if_pc = 32'h80;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h84) begin
            n_err++; $display("[TB] FAIL midop_discard got %0b/%h want 0/00000084", pred_taken, pred_target);
        end
        n_cmp++;
        if (perf_lookups !== 32'h0 || perf_mispredicts !== 32'h0) begin
            n_err++; $display("[TB] FAIL midop_perf got %0d/%0d want 0/0", perf_lookups, perf_mispredicts);
        end
    endtask

    task automatic test_random();
        logic        exp_t;
        logic [31:0] exp_tgt;
        logic [31:0] exp_redir;
        logic        exp_mp;
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset = ($urandom_range(0, 59) == 0);
            stall = ($urandom_range(0, 3) == 0);
            if_pc = 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2));
            if ($urandom_range(0, 7) == 0) if_pc = if_pc | ($urandom & 32'hFFFF_C000);
            set_upd($urandom_range(0, 1) == 1,
                    32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2)),
                    $urandom_range(0, 2) != 0,
                    32'($urandom_range(1, 8) << 4),
                    $urandom_range(0, 1) == 1,
                    32'($urandom_range(1, 8) << 4));
            upd_is_jump = ($urandom_range(0, 5) == 0);
            #1;
            model_predict(if_pc, reset, exp_t, exp_tgt);
            exp_mp    = model_mispredict();
            exp_redir = upd_taken ? upd_target : upd_pc + 32'd4;
            n_cmp++;
            if (pred_taken !== exp_t || pred_target !== exp_tgt) begin
                n_err++; $display("[TB] FAIL rand_pred cyc %0d pc %h got %0b/%h want %0b/%h",
                                  cyc, if_pc, pred_taken, pred_target, exp_t, exp_tgt);
            end
            n_cmp++;
            if (mispredict !== exp_mp || redirect_pc !== exp_redir) begin
                n_err++; $display("[TB] FAIL rand_resolve cyc %0d got %0b/%h want %0b/%h",
                                  cyc, mispredict, redirect_pc, exp_mp, exp_redir);
            end
            n_cmp++;
            if (perf_lookups !== m_lookups || perf_mispredicts !== m_mis) begin
                n_err++; $display("[TB] FAIL rand_perf cyc %0d got %0d/%0d want %0d/%0d",
                                  cyc, perf_lookups, perf_mispredicts, m_lookups, m_mis);
            end
            tick();
        end
        reset = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        m_lookups = 0;
        m_mis     = 0;
        for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k]  = 1'b0;
            m_tag[k]    = 0;
            m_target[k] = 32'h0;
            m_jump[k]   = 1'b0;
            m_ctr[k]    = 0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_pc_wrap();
        test_allocate();
        test_saturation();
        test_alias();
        test_stall();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
